// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and state encoding for the registered
// 1-to-8 demultiplexer / serial-to-parallel collector.
//   N_OUT   : number of demux outputs (fixed at 8)
//   SEL_W   : width of the select and of the auto-mode index counter
//   state_t : collector state, IDLE (no partial auto frame) or FILL
package demux_pkg;

    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/demux_idx_cnt.sv
// demux_idx_cnt: wrapping auto-mode index counter.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset, cnt -> 0
//   clr     in   synchronous return to index 0 (wins over inc)
//   inc     in   advance by one, wrapping N_OUT-1 -> 0
//   cnt     out  current index
//   at_last out  cnt is at the final index of a frame
module demux_idx_cnt
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] cnt,
    output logic             at_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            // Natural SEL_W-bit overflow gives the 7 -> 0 wrap.
            cnt <= cnt + 1'b1;
        end
    end

    assign at_last = (cnt == SEL_W'(N_OUT - 1));

endmodule

// File: rtl/demux_1_8_reg.sv
// demux_1_8_reg: registered 1-to-8 demux and serial-to-parallel collector.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   din         in   serial data bit
//   sel         in   output index used when auto=0
//   load        in   write strobe
//   auto        in   1 = internal counter index, 0 = sel index
//   clr         in   synchronous clear of y, cnt and state (not frame)
//   y           out  live demux register bank
//   frame       out  last completed auto-mode frame
//   frame_valid out  one-cycle pulse when frame updates
//   abort       out  one-cycle pulse when a partial auto frame is dropped
//   cnt         out  current auto index
//   busy        out  high while a partial auto frame is in progress (FILL)
//
// Handshake: load is a plain strobe with no back-pressure; din/sel/auto
// are sampled at every rising edge where load=1 and clr=0. frame_valid
// and abort are single-cycle strobes with no acknowledge.
module demux_1_8_reg
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    input  logic             auto,
    input  logic             clr,
    output logic [N_OUT-1:0] y,
    output logic [N_OUT-1:0] frame,
    output logic             frame_valid,
    output logic             abort,
    output logic [SEL_W-1:0] cnt,
    output logic             busy
);

    state_t           state;
    logic             wr;
    logic             auto_wr;
    logic             man_wr;
    logic             man_abort;
    logic             at_last;
    logic [SEL_W-1:0] idx;

    // clr beats load: a write coinciding with clr is dropped.
    assign wr        = load & ~clr;
    assign auto_wr   = wr & auto;
    assign man_wr    = wr & ~auto;
    // A manual write during FILL discards the partial auto frame.
    assign man_abort = man_wr & (state == FILL);
    assign idx       = auto ? cnt : sel;

    demux_idx_cnt u_idx_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr | man_abort | (auto_wr & at_last)),
        .inc     (auto_wr & ~at_last),
        .cnt     (cnt),
        .at_last (at_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y           <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            abort       <= 1'b0;
            state       <= IDLE;
        end else begin
            frame_valid <= 1'b0;
            abort       <= 1'b0;
            if (clr) begin
                y     <= '0;
                state <= IDLE;
            end else if (wr) begin
                y[idx] <= din;
                if (man_abort) begin
                    abort <= 1'b1;
                    state <= IDLE;
                end else if (auto_wr) begin
                    if (at_last) begin
                        // Bit 7 arrives now; bits 6..0 are already in y.
                        frame       <= {din, y[N_OUT-2:0]};
                        frame_valid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= FILL;
                    end
                end
            end
        end
    end

    assign busy = (state == FILL);

endmodule

// File: tb/tb_demux_1_8_reg.sv
// tb_demux_1_8_reg: self-checking bench for demux_1_8_reg. A small
// behavioural model tracks y/cnt/busy/pulses; completed frames are pushed
// to exp_q when the completing write is driven and popped on frame_valid.
module tb_demux_1_8_reg;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic [2:0] sel;
    logic       load;
    logic       auto;
    logic       clr;
    logic [7:0] y;
    logic [7:0] frame;
    logic       frame_valid;
    logic       abort;
    logic [2:0] cnt;
    logic       busy;

    demux_1_8_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .sel         (sel),
        .load        (load),
        .auto        (auto),
        .clr         (clr),
        .y           (y),
        .frame       (frame),
        .frame_valid (frame_valid),
        .abort       (abort),
        .cnt         (cnt),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;
    int         last_fv_cycle = -1;

    logic [7:0] m_y;
    logic [7:0] m_frame;
    logic [2:0] m_cnt;
    logic       m_fill;
    logic       m_fv;
    logic       m_ab;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_y = '0; m_frame = '0; m_cnt = '0; m_fill = 1'b0; m_fv = 1'b0; m_ab = 1'b0;
    endtask

    task automatic compare_all();
        check("y", y, m_y);
        check("cnt", {5'd0, cnt}, {5'd0, m_cnt});
        check("busy", {7'd0, busy}, {7'd0, m_fill});
        check("frame_valid", {7'd0, frame_valid}, {7'd0, m_fv});
        check("abort", {7'd0, abort}, {7'd0, m_ab});
        check("frame_reg", frame, m_frame);
        if (frame_valid) begin
            if (exp_q.size() == 0) check("frame_unexpected", 8'd1, 8'd0);
            else check("frame_sb", frame, exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic ld, input logic au, input logic [2:0] s,
                        input logic d, input logic c);
        logic [7:0] f;
        @(negedge clk);
        load = ld; auto = au; sel = s; din = d; clr = c;
        @(posedge clk);
        #1;
        cycle++;
        m_fv = 1'b0;
        m_ab = 1'b0;
        if (c) begin
            m_y = '0; m_cnt = '0; m_fill = 1'b0;
        end else if (ld) begin
            if (au) begin
                m_y[m_cnt] = d;
                if (m_cnt == 3'd7) begin
                    f = m_y;
                    exp_q.push_back(f);
                    m_frame = f;
                    m_fv = 1'b1;
                    m_cnt = 3'd0;
                    m_fill = 1'b0;
                end else begin
                    m_cnt = m_cnt + 3'd1;
                    m_fill = 1'b1;
                end
            end else begin
                m_y[s] = d;
                if (m_fill) begin
                    m_ab = 1'b1;
                    m_cnt = 3'd0;
                    m_fill = 1'b0;
                end
            end
        end
        if (m_fv) last_fv_cycle = cycle;
        compare_all();
        load = 1'b0; clr = 1'b0;
    endtask

    task automatic auto_byte(input logic [7:0] b, input bit gapped);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 3'($urandom_range(0, 7)), b[i], 1'b0);
            if (gapped && i < 7) step(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] sweep_din;
        int         first_fv;
        rst_n = 1'b1; din = 1'b0; sel = '0; load = 1'b0; auto = 1'b0; clr = 1'b0;
        model_reset();

        // Reset asserted mid-cycle: outputs clear without waiting for a clock.
        #13 rst_n = 1'b0;
        #1;
        check("rst_y", y, 8'h00);
        check("rst_frame", frame, 8'h00);
        check("rst_cnt", {5'd0, cnt}, 8'h00);
        check("rst_pulses", {6'd0, frame_valid, abort}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1, 1'b0);
        check("idle_y", y, 8'h00);

        // Manual sweep.
        sweep_din = 8'b0111_0101;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'(i), sweep_din[i], 1'b0);
        check("sweep_y", y, 8'b0111_0101);
        check("sweep_cnt", {5'd0, cnt}, 8'h00);

        // Auto frame followed back-to-back by an all-ones frame.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        auto_byte(8'b0111_0101, 1'b0);
        check("auto1_frame", frame, 8'b0111_0101);
        first_fv = last_fv_cycle;
        auto_byte(8'hFF, 1'b0);
        check("auto2_frame", frame, 8'hFF);
        check("auto2_spacing", 8'(last_fv_cycle - first_fv), 8'd8);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check("pulse_one_cycle", {7'd0, frame_valid}, 8'h00);

        // Gapped auto frame.
        auto_byte(8'b0111_0101, 1'b1);
        check("gapped_frame", frame, 8'b0111_0101);

        // Abort: partial frame then a manual write.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        check("abort_pulse", {7'd0, abort}, 8'h01);
        check("abort_y5", {7'd0, y[5]}, 8'h01);
        check("abort_cnt", {5'd0, cnt}, 8'h00);
        check("abort_frame", frame, 8'b0111_0101);

        // Clear beats a simultaneous auto write.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
        check("clr_y", y, 8'h00);
        check("clr_cnt", {5'd0, cnt}, 8'h00);
        check("clr_abort", {7'd0, abort}, 8'h00);

        // Random mix.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 30) == 0));

        // Asynchronous reset at cnt=4.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        check("pre_rst_cnt", {5'd0, cnt}, 8'h04);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_y", y, 8'h00);
        check("arst_cnt", {5'd0, cnt}, 8'h00);
        check("arst_frame", frame, 8'h00);
        check("arst_pulses", {6'd0, frame_valid, abort}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        check("frames_left", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_8_reg.md
Name: demux_1_8_reg

Overview:
- Registered 1-to-8 demultiplexer and serial-to-parallel collector; the receive-side counterpart of the team's mux_8_1.
- Manual mode: each strobed input bit is steered into the output bit addressed by sel.
- Auto mode: an internal index counter fills bits 0..7 in order, then publishes a completed 8-bit frame with a one-cycle valid pulse.
- Sits on the far end of a link driven by mux_8_1 with an incrementing select, and rebuilds the original byte.

Parameters:
- N_OUT, 8, number of outputs. Fixed at 8; other values are unsupported.
- SEL_W, 3, select and counter width (log2 of N_OUT).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- sel  input  3  output index; used only when auto=0.
- load  input  1  write strobe; din is captured when load=1 at a rising edge.
- auto  input  1  1 = use the internal counter index; 0 = use sel.
- clr  input  1  synchronous clear of y, cnt and state; does not touch frame.
- y  output  8  live demux register bank.
- frame  output  8  last completed auto-mode frame.
- frame_valid  output  1  one-cycle pulse when frame updates.
- abort  output  1  one-cycle pulse when a partial auto frame is discarded.
- cnt  output  3  current auto index.
- busy  output  1  high while in FILL.

Behaviour:
- Reset (rst_n=0, asynchronous): y=0, frame=0, cnt=0, frame_valid=0, abort=0, state=IDLE.
  - Reset asserted mid-frame discards the partial frame without an abort pulse.
- Latency: a write at edge k is visible on y after edge k. frame and frame_valid update at the same edge as the write of index 7.
- The state machine has two states, IDLE and FILL. busy=1 only in FILL.
- Manual write (load=1, auto=0):
  - y[sel] <= din. All other y bits hold.
  - In IDLE, cnt is unchanged.
  - In FILL, the write still happens, plus: abort pulses, cnt <= 0, state <= IDLE.
- Auto write (load=1, auto=1):
  - y[cnt] <= din and cnt <= cnt+1, wrapping 7 to 0.
  - IDLE to FILL on the write at cnt=0.
  - At cnt=7: frame <= {din, y[6:0]}, frame_valid=1, cnt <= 0, state <= IDLE.
- Idle cycle (load=0): everything holds; auto and sel are ignored.
- clr=1: y <= 0, cnt <= 0, state <= IDLE, no abort pulse.
  - clr beats load in the same cycle; that write is dropped.
- frame_valid and abort are never both high. Each is low on every cycle other than its event cycle.
- Back-to-back frames need no idle cycle: the write at cnt=0 immediately after a completing write starts the next frame.
- Bits of y stay stale from the previous frame until they are overwritten; only frame is guaranteed coherent.

Decomposition:
- Shared package (demux_pkg):
  - N_OUT and SEL_W constants.
  - State enum: IDLE=1'b0, FILL=1'b1.
- One sub-module, demux_idx_cnt: the 3-bit wrapping counter with inc, clr and at_last outputs.
- The top level holds the y bank, frame register, FSM and pulse generation.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately; then 5 idle cycles -> y=0, frame_valid=0.
- Manual sweep: apply (sel,din) pairs (0,1) (1,0) (2,1) (3,0) (4,1) (5,1) (6,1) (7,0), one per cycle with load=1 and auto=0 -> y=8'b01110101, cnt=0, frame_valid never high.
- Auto frame: with auto=1, feed din=1,0,1,0,1,1,1,0 on consecutive loads -> on the 8th edge frame=8'b01110101 and frame_valid pulses exactly 1 cycle, busy falls, cnt=0.
  - Feed immediately into a second frame of all 1s -> frame=8'hFF, pulse 8 cycles after the first.
- Gapped auto: same 8 bits with load deasserted on alternate cycles -> identical frame; busy held for the whole frame.
- Abort: 3 auto writes, then a manual write sel=5 din=1 -> abort pulse, cnt=0, y[5]=1, frame unchanged.
- Clear priority: mid-frame, assert clr=1 with load=1 and auto=1 -> y=0, cnt=0, no abort, no write.
  - Separately, assert rst_n=0 at cnt=4 -> outputs 0 asynchronously, no pulses.
